// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-addressed unaligned SRAM.
// Holds the FSM state type, lane-width derivation and the byte-shift helper.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SECOND,
        RESP
    } state_t;

    function automatic int bytes_of(input int dw);
        return dw / 8;
    endfunction

    function automatic int off_w_of(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Lane of the two-word window that feeds output byte `lane`.
    function automatic int win_lane(input int lane, input int off);
        return lane + off;
    endfunction

endpackage

// File: rtl/sram_be_bank.sv
// Single-port storage array with per-byte write enables.
// Read data is registered; contents are never reset.
module sram_be_bank
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int N_ENTRIES  = 1024
) (
    input  logic                              clk,
    input  logic                              en,
    input  logic                              we,
    input  logic [$clog2(N_ENTRIES)-1:0]      addr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [bytes_of(DATA_WIDTH)-1:0]   be,
    output logic [DATA_WIDTH-1:0]             rdata
);

    localparam int BYTES = bytes_of(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [N_ENTRIES];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_unaligned_be.sv
// Byte-addressed SRAM front end splitting unaligned accesses into two words.
// Optional SRAM_OUT_REG_EN adds one register stage on the response.
module sram_unaligned_be
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int N_ENTRIES  = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [ADDR_WIDTH-1:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0]           req_wdata_i,
    input  logic [bytes_of(DATA_WIDTH)-1:0] req_be_i,
    output logic                            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
    output logic                            rsp_err_o
);

    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int OFF_W = off_w_of(DATA_WIDTH);
    localparam int IDX_W = $clog2(N_ENTRIES);

    state_t state, state_nx;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] widx;
    logic             oor;

    assign off  = req_addr_i[OFF_W-1:0];
    assign widx = req_addr_i[OFF_W +: IDX_W];

    generate
        if (ADDR_WIDTH > IDX_W + OFF_W) begin : g_range
            assign oor = |req_addr_i[ADDR_WIDTH-1:IDX_W+OFF_W];
        end else begin : g_norange
            assign oor = 1'b0;
        end
    endgenerate

    // Request placed into a two-word window starting at word w.
    logic [2*BYTES-1:0]      win_be;
    logic [2*DATA_WIDTH-1:0] win_data;

    assign win_be   = {{BYTES{1'b0}}, req_be_i} << off;
    assign win_data = {{DATA_WIDTH{1'b0}}, req_wdata_i} << {off, 3'b000};

    logic                  accept;
    logic                  cur_we;
    logic                  cur_err;
    logic [OFF_W-1:0]      cur_off;
    logic [IDX_W-1:0]      next_idx;
    logic [BYTES-1:0]      hi_be;
    logic [DATA_WIDTH-1:0] hi_data;
    logic [DATA_WIDTH-1:0] lo_word;

    logic                  bank_en;
    logic                  bank_we;
    logic [IDX_W-1:0]      bank_addr;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [BYTES-1:0]      bank_be;
    logic [DATA_WIDTH-1:0] bank_rdata;

    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i && (state == IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        bank_addr  = widx;
        bank_wdata = win_data[DATA_WIDTH-1:0];
        bank_be    = win_be[BYTES-1:0];
        unique case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (oor) begin
                        state_nx = RESP;
                    end else begin
                        bank_en = 1'b1;
                        bank_we = req_we_i;
                        if (req_we_i ? (|win_be[2*BYTES-1:BYTES])
                                     : (off != '0)) begin
                            state_nx = SECOND;
                        end else begin
                            state_nx = RESP;
                        end
                    end
                end
            end
            SECOND: begin
                bank_en    = 1'b1;
                bank_we    = cur_we;
                bank_addr  = next_idx;
                bank_wdata = hi_data;
                bank_be    = hi_be;
                state_nx   = RESP;
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cur_we   <= 1'b0;
            cur_err  <= 1'b0;
            cur_off  <= '0;
            next_idx <= '0;
            hi_be    <= '0;
            hi_data  <= '0;
            lo_word  <= '0;
        end else begin
            if (accept) begin
                cur_we   <= req_we_i;
                cur_err  <= oor;
                cur_off  <= off;
                next_idx <= widx + IDX_W'(1);
                hi_be    <= win_be[2*BYTES-1:BYTES];
                hi_data  <= win_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            if (state == SECOND) begin
                lo_word <= bank_rdata;
            end
        end
    end

    sram_be_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_ENTRIES  (N_ENTRIES)
    ) u_bank (
        .clk   (clk_i),
        .en    (bank_en),
        .we    (bank_we),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .be    (bank_be),
        .rdata (bank_rdata)
    );

    logic [DATA_WIDTH-1:0]   lo_sel;
    logic [2*DATA_WIDTH-1:0] window;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    rsp_valid;
    logic                    rsp_err;
    logic [DATA_WIDTH-1:0]   rsp_rdata;

    // Aligned reads use the fresh bank word as the low half.
    always_comb begin
        lo_sel = (cur_off != '0) ? lo_word : bank_rdata;
        window = {bank_rdata, lo_sel};
        merged = '0;
        for (int i = 0; i < BYTES; i++) begin
            merged[8*i +: 8] = window[8*win_lane(i, int'(cur_off)) +: 8];
        end
    end

    always_comb begin
        rsp_valid = (state == RESP);
        rsp_err   = rsp_valid && cur_err;
        rsp_rdata = '0;
        if (rsp_valid && !cur_we && !cur_err) begin
            rsp_rdata = merged;
        end
    end

`ifdef SRAM_OUT_REG_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= rsp_valid;
            rsp_err_o   <= rsp_err;
            rsp_rdata_o <= rsp_rdata;
        end
    end
`else
    assign rsp_valid_o = rsp_valid;
    assign rsp_err_o   = rsp_err;
    assign rsp_rdata_o = rsp_rdata;
`endif

endmodule
